key_operand_calc: RTL and testbench
===================================

// Module: key_operand_calc
// PURPOSE
//  Parametrised two-button operand-entry calculator for the DE0-Nano-SoC.
//  KEY[1] presses count up the current operand; KEY[0] presses advance to the next operand.
//  After NUM_OPS operands, the block multiplies or sums them over several cycles.
//  The result is shown on LED with an overflow flag.
//  Adds button synchronisation and debounce, saturating counters, and a selectable mode.
//  Sits directly between the board KEY/LED pins and CLOCK_50.
// PARAMETERS
//  CNT_W      4      width of each operand counter (1..8)
//  NUM_OPS    2      number of operands entered per calculation (2..8)
//  LED_W      8      number of LED outputs (>= CNT_W+4)
//  DEB_CYCLES 50000  cycles a synchronised key level must hold stable before it is accepted
//  RES_W      NUM_OPS*CNT_W  result width (localparam, not overridable)
// PORTS
//  CLOCK_50  in   1        system clock; all logic is on its rising edge
//  RESET     in   1        synchronous, active-high reset
//  KEY       in   2        push buttons, active-low; KEY[1]=increment, KEY[0]=advance
//  MODE      in   1        0=product, 1=sum; sampled on entry to CALC
//  LED       out  LED_W    status / result display
//  RESULT    out  RES_W    full-width result, valid while DONE=1
//  OVF       out  1        RESULT does not fit in LED_W bits
//  DONE      out  1        high in SHOW state
// BEHAVIOUR
//  Reset:
//   - RESET=1 at any clock edge, mid-operation included, forces:
//     state=CLEAR, all operands=0, idx=0, RESULT=0, OVF=0, DONE=0, LED=0.
//   - Debounce counters clear; the debounced key levels are set to 1 (released).
//  Key input conditioning:
//   - Each KEY bit passes through a 2-flop synchroniser, then a stable-level filter.
//   - The filter's debounced level changes only after DEB_CYCLES consecutive equal samples.
//   - A press event is a 1->0 transition of the debounced level, one cycle wide.
//   - Holding a key gives exactly one event. Release gives no event.
//  State machine:
//   - CLEAR: clears operands and idx to 0; goes to ENTRY next cycle.
//   - ENTRY, on an inc event: op[idx] += 1, saturating at 2^CNT_W-1 (no wrap).
//   - ENTRY, on an adv event: if idx==NUM_OPS-1, go to CALC; otherwise idx += 1.
//   - Simultaneous inc and adv in the same cycle: the increment applies to the current op[idx], then the advance takes effect.
//   - CALC: latches MODE.
//     * acc starts at op[0].
//     * Each subsequent cycle, op[k] is folded into acc (acc*op[k] or acc+op[k]).
//     * Takes exactly NUM_OPS-1 cycles, then moves to SHOW. Key events are ignored in CALC.
//     * Arithmetic is unsigned at RES_W bits; the product of NUM_OPS CNT_W-bit values cannot overflow RES_W.
//   - SHOW: RESULT=acc, DONE=1.
//     * OVF=1 iff acc >= 2^LED_W.
//     * An adv event goes to CLEAR; inc events are ignored.
//  LED mapping:
//   - CLEAR: all 0.
//   - ENTRY:
//     * LED[0]=1
//     * LED[3:1]=idx
//     * LED[CNT_W+3:4]=op[idx] (live count)
//     * all other bits 0
//   - CALC: LED[0]=1, all others 0.
//   - SHOW: LED = acc[LED_W-1:0] if OVF=0, otherwise all 1s (saturated display).
//  Registered outputs:
//   - All outputs are registered and update on the same edge as the state change.
//   - Latency from the final adv event to DONE=1 is NUM_OPS cycles: NUM_OPS-1 in CALC, plus the registered transition into SHOW.
// TESTING (bench uses DEB_CYCLES=4, default CNT_W/NUM_OPS/LED_W)
//  1. 3 inc presses, adv, 5 inc presses, adv, MODE=0 -> DONE=1 after 2 cycles, RESULT=15, LED=8'h0F, OVF=0.
//  2. Enter 15 and 15, MODE=0 -> RESULT=225, LED=8'hE1, OVF=0.
//     Then an 18th inc press on a CNT_W=4 operand -> operand stays at 15 (saturation).
//  3. NUM_OPS=3, operands 15,15,15, MODE=0 -> RESULT=3375, OVF=1, LED=8'hFF.
//     Same operands with MODE=1 -> RESULT=45, OVF=0.
//  4. Glitchy KEY[1] (low pulses of 1-3 cycles, then a low held 10 cycles) -> exactly one increment.
//     Key held low for 1000 cycles -> one increment.
//  5. inc and adv debounced events in the same cycle with idx=0, op0=2 -> op0=3, then idx=1.
//     In SHOW, an inc press leaves RESULT unchanged; an adv press gives CLEAR, then ENTRY, with LED=8'h01.
//  6. RESET asserted for 1 cycle while in CALC and while in ENTRY with op0=7 -> next cycle all outputs 0 and state CLEAR.
//     A following entry 2,2 -> RESULT=4.

Source files
------------

// File: rtl/key_operand_calc.sv
// key_operand_calc: debounced two-key operand entry feeding a multi-cycle product/sum with LED display
module key_operand_calc #(
  parameter int CNT_W      = 4,
  parameter int NUM_OPS    = 2,
  parameter int LED_W      = 8,
  parameter int DEB_CYCLES = 50000
) (
  input  logic                     CLOCK_50,
  input  logic                     RESET,
  input  logic [1:0]               KEY,
  input  logic                     MODE,
  output logic [LED_W-1:0]         LED,
  output logic [NUM_OPS*CNT_W-1:0] RESULT,
  output logic                     OVF,
  output logic                     DONE
);
  localparam int RES_W = NUM_OPS*CNT_W;
  localparam int IW    = $clog2(NUM_OPS);
  localparam int DW    = $clog2(DEB_CYCLES+1);
  typedef enum logic [1:0] {CLEAR, ENTRY, CALC, SHOW} state_t;
  logic [1:0] s1_q, s2_q, deb_q, deb_d, ev_q, ev_d, hit;
  logic [DW-1:0] cnt_q [2];
  logic [DW-1:0] cnt_d [2];
  state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d, k_q, k_d;
  logic [CNT_W-1:0] op_q [NUM_OPS];
  logic [CNT_W-1:0] op_d [NUM_OPS];
  logic [RES_W-1:0] acc_q, acc_d, opx, res_q, res_d;
  logic [LED_W-1:0] led_q, led_d;
  logic mode_q, mode_d, ovf_q, ovf_d, done_q, done_d, inc, adv;
  // A level is accepted only after DEB_CYCLES consecutive samples disagree with the current one
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      hit[i]   = s2_q[i] != deb_q[i] && cnt_q[i] == DW'(DEB_CYCLES-1);
      deb_d[i] = hit[i] ? s2_q[i] : deb_q[i];
      cnt_d[i] = (s2_q[i] == deb_q[i] || hit[i]) ? '0 : cnt_q[i] + 1'b1;
    end
    ev_d = deb_q & ~deb_d;
  end
  assign inc = ev_q[1];
  assign adv = ev_q[0];
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    k_d     = k_q;
    op_d    = op_q;
    acc_d   = acc_q;
    mode_d  = mode_q;
    opx     = RES_W'(op_q[k_q]);
    case (state_q)
      CLEAR: begin
        state_d = ENTRY;
        idx_d   = '0;
        op_d    = '{default: '0};
      end
      ENTRY: begin
        if (inc) op_d[idx_q] = &op_q[idx_q] ? op_q[idx_q] : op_q[idx_q] + 1'b1;
        if (adv && idx_q == IW'(NUM_OPS-1)) begin
          state_d = CALC;
          mode_d  = MODE;
          acc_d   = RES_W'(op_d[0]);
          k_d     = IW'(1);
        end else if (adv) idx_d = idx_q + 1'b1;
      end
      CALC: begin
        acc_d   = mode_q ? acc_q + opx : acc_q * opx;
        k_d     = k_q + 1'b1;
        state_d = k_q == IW'(NUM_OPS-1) ? SHOW : CALC;
      end
      SHOW: state_d = adv ? CLEAR : SHOW;
    endcase
    // Outputs are derived from next-state values so they move on the same edge as the state
    done_d = state_d == SHOW;
    ovf_d  = done_d && (acc_d >> LED_W) != '0;
    res_d  = done_d ? acc_d : '0;
    led_d  = state_d == ENTRY ? LED_W'({op_d[idx_d], 3'(idx_d), 1'b1}) :
             state_d == CALC  ? LED_W'(1) :
             done_d           ? (ovf_d ? '1 : LED_W'(acc_d)) : '0;
  end
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      s1_q    <= 2'b11;
      s2_q    <= 2'b11;
      deb_q   <= 2'b11;
      cnt_q   <= '{default: '0};
      ev_q    <= '0;
      state_q <= CLEAR;
      idx_q   <= '0;
      k_q     <= '0;
      op_q    <= '{default: '0};
      acc_q   <= '0;
      mode_q  <= 1'b0;
      led_q   <= '0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      s1_q    <= KEY;
      s2_q    <= s1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
      ev_q    <= ev_d;
      state_q <= state_d;
      idx_q   <= idx_d;
      k_q     <= k_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      mode_q  <= mode_d;
      led_q   <= led_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end
  assign LED    = led_q;
  assign RESULT = res_q;
  assign OVF    = ovf_q;
  assign DONE   = done_q;
endmodule

// File: tb/tb_key_operand_calc.sv
// tb_key_operand_calc: directed key-press scenarios on a 2-operand and a 3-operand calculator
module tb_key_operand_calc;
  logic clk = 0, rst = 1, mode_a = 0, mode_b = 0;
  logic [1:0] ka = 2'b11, kb = 2'b11;
  logic [7:0] led_a, led_b, res_a;
  logic [11:0] res_b;
  logic ovf_a, ovf_b, done_a, done_b;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  key_operand_calc #(.DEB_CYCLES(4)) dut_a (
    .CLOCK_50(clk), .RESET(rst), .KEY(ka), .MODE(mode_a),
    .LED(led_a), .RESULT(res_a), .OVF(ovf_a), .DONE(done_a));
  key_operand_calc #(.NUM_OPS(3), .DEB_CYCLES(4)) dut_b (
    .CLOCK_50(clk), .RESET(rst), .KEY(kb), .MODE(mode_b),
    .LED(led_b), .RESULT(res_b), .OVF(ovf_b), .DONE(done_b));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task automatic setk(input bit d, input int b, input logic v);
    if (d) kb[b] = v; else ka[b] = v;
  endtask
  task automatic press(input bit d, input int b, input int n = 1, input int low = 10);
    repeat (n) begin
      setk(d, b, 1'b0);
      tick(low);
      setk(d, b, 1'b1);
      tick(10);
    end
  endtask
  task automatic go_calc(input bit d);
    int t = 0;
    setk(d, 0, 1'b0);
    do begin tick(); t++; end while ((d ? led_b : led_a) != 8'h01 && t < 30);
    setk(d, 0, 1'b1);
    chk("calc_entry", t < 30, 1);
    chk("calc_done_low", d ? done_b : done_a, 0);
  endtask
  task automatic finish_calc(input bit d, input int exp_cyc);
    int t = 0;
    while (!(d ? done_b : done_a) && t < 20) begin tick(); t++; end
    chk("calc_cycles", t, exp_cyc);
  endtask
  task automatic to_clear(input bit d);
    int t = 0;
    setk(d, 0, 1'b0);
    do begin tick(); t++; end while ((d ? done_b : done_a) && t < 30);
    setk(d, 0, 1'b1);
    chk("clear_seen", t < 30, 1);
    chk("clear_led", d ? led_b : led_a, 0);
    tick();
    chk("entry_led", d ? led_b : led_a, 8'h01);
    tick(10);
  endtask
  initial begin
    tick(3);
    chk("rst_led", led_a, 0);
    chk("rst_res", res_a, 0);
    chk("rst_ovf", ovf_a, 0);
    chk("rst_done", done_a, 0);
    rst = 0;
    tick(2);
    chk("idle_entry", led_a, 8'h01);
    press(0, 1, 3);
    chk("op0_3", led_a, 8'h31);
    press(0, 0);
    chk("idx1", led_a, 8'h03);
    press(0, 1, 5);
    chk("op1_5", led_a, 8'h53);
    go_calc(0);
    finish_calc(0, 1);
    chk("prod15_res", res_a, 15);
    chk("prod15_led", led_a, 8'h0F);
    chk("prod15_ovf", ovf_a, 0);
    tick(10);
    press(0, 1);
    chk("show_inc_res", res_a, 15);
    chk("show_inc_done", done_a, 1);
    to_clear(0);
    press(0, 1, 15);
    chk("op0_15", led_a, 8'hF1);
    press(0, 0);
    press(0, 1, 18);
    chk("sat_op1", led_a, 8'hF3);
    go_calc(0);
    finish_calc(0, 1);
    chk("prod225_res", res_a, 225);
    chk("prod225_led", led_a, 8'hE1);
    chk("prod225_ovf", ovf_a, 0);
    tick(10);
    to_clear(0);
    press(0, 1, 1, 1);
    press(0, 1, 1, 2);
    press(0, 1, 1, 3);
    chk("glitch_none", led_a, 8'h01);
    press(0, 1, 1, 10);
    chk("glitch_one", led_a, 8'h11);
    press(0, 1, 1, 1000);
    chk("long_hold", led_a, 8'h21);
    ka = 2'b00;
    tick(10);
    ka = 2'b11;
    tick(10);
    chk("simul_idx1", led_a, 8'h03);
    press(0, 1, 2);
    go_calc(0);
    finish_calc(0, 1);
    chk("simul_res", res_a, 6);
    tick(10);
    to_clear(0);
    press(0, 1, 7);
    chk("op0_7", led_a, 8'h71);
    rst = 1;
    tick();
    rst = 0;
    chk("rst_entry_led", led_a, 0);
    chk("rst_entry_res", res_a, 0);
    chk("rst_entry_done", done_a, 0);
    chk("rst_entry_ovf", ovf_a, 0);
    tick();
    chk("rst_entry_clear", led_a, 8'h01);
    press(0, 1, 2);
    press(0, 0);
    press(0, 1, 2);
    go_calc(0);
    rst = 1;
    tick();
    rst = 0;
    chk("rst_calc_led", led_a, 0);
    chk("rst_calc_done", done_a, 0);
    chk("rst_calc_res", res_a, 0);
    tick(10);
    chk("rst_calc_entry", led_a, 8'h01);
    press(0, 1, 2);
    press(0, 0);
    press(0, 1, 2);
    go_calc(0);
    finish_calc(0, 1);
    chk("after_rst_res", res_a, 4);
    for (int m = 0; m < 2; m++) begin
      press(1, 1, 15);
      press(1, 0);
      press(1, 1, 15);
      press(1, 0);
      press(1, 1, 15);
      chk("b_op2", led_b, 8'hF5);
      mode_b = m[0];
      go_calc(1);
      finish_calc(1, 2);
      chk("b_res", res_b, m == 0 ? 3375 : 45);
      chk("b_ovf", ovf_b, m == 0 ? 1 : 0);
      chk("b_led", led_b, m == 0 ? 8'hFF : 8'h2D);
      tick(10);
      to_clear(1);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
